// File: rtl/int_ctrl.sv
// Vectored interrupt controller: fixed lowest-index priority, nesting through in-service bits, per-channel edge/level mode.
// An irq edge sets pending on edge k and raises int_req after edge k+1; a request holds its id/vector until int_ack.
module int_ctrl #(
  parameter int          NCH        = 4,
  parameter int          AW         = 10,
  parameter int unsigned VEC_BASE   = 32'h3C0,
  parameter int unsigned VEC_STRIDE = 16,
  localparam int         IW         = $clog2(NCH)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [NCH-1:0] irq,
  input  logic           we_en,
  input  logic [NCH-1:0] en_in,
  input  logic           we_mode,
  input  logic [NCH-1:0] mode_in,
  input  logic           we_vec,
  input  logic [IW-1:0]  vec_sel,
  input  logic [AW-1:0]  vec_in,
  input  logic           int_ack,
  input  logic           int_ret,
  output logic           int_req,
  output logic [AW-1:0]  int_vec,
  output logic [IW-1:0]  int_id,
  output logic [NCH-1:0] pending,
  output logic [NCH-1:0] in_service
);

  localparam logic [NCH-1:0] ONE = NCH'(1);

  typedef enum logic {S_IDLE, S_REQ} state_e;

  state_e         state_q, state_d;
  logic [NCH-1:0] irq_d_q;
  logic [NCH-1:0] pend_q, pend_d;
  logic [NCH-1:0] isv_q, isv_d;
  logic [NCH-1:0] en_q, en_d;
  logic [NCH-1:0] mode_q, mode_d;
  logic [AW-1:0]  vec_q [NCH];
  logic [AW-1:0]  vec_d [NCH];
  logic [AW-1:0]  ivec_q, ivec_d;
  logic [IW-1:0]  iid_q, iid_d;

  logic [NCH-1:0] rise;
  logic [NCH-1:0] isv_low;
  logic [NCH-1:0] prio_mask;
  logic [NCH-1:0] elig;
  logic [IW-1:0]  win_id;
  logic           ack_fire;

  // Only channels above the lowest active service level may interrupt it.
  always_comb begin
    rise      = irq & ~irq_d_q;
    ack_fire  = (state_q == S_REQ) && int_ack;
    isv_low   = isv_q & (~isv_q + ONE);
    prio_mask = (isv_q == '0) ? '1 : (isv_low - ONE);
    elig      = pend_q & en_q & prio_mask;
    win_id    = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (elig[i]) win_id = IW'(i);
    end
  end

  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      if (mode_q[i]) begin
        pend_d[i] = rise[i] | (pend_q[i] & ~(ack_fire && (iid_q == IW'(i))));
      end else begin
        pend_d[i] = irq[i];
      end
    end
  end

  // Return retires the innermost level before a same-cycle ack opens a new one.
  always_comb begin
    isv_d = int_ret ? (isv_q & ~isv_low) : isv_q;
    if (ack_fire) isv_d[iid_q] = 1'b1;
  end

  always_comb begin
    en_d   = we_en   ? en_in   : en_q;
    mode_d = we_mode ? mode_in : mode_q;
    for (int i = 0; i < NCH; i++) begin
      vec_d[i] = (we_vec && (int'(vec_sel) == i)) ? vec_in : vec_q[i];
    end
  end

  always_comb begin
    state_d = state_q;
    iid_d   = iid_q;
    ivec_d  = ivec_q;
    case (state_q)
      S_IDLE: begin
        if (elig != '0) begin
          state_d = S_REQ;
          iid_d   = win_id;
          ivec_d  = vec_q[win_id];
        end
      end
      S_REQ: begin
        if (int_ack) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      irq_d_q <= '0;
      pend_q  <= '0;
      isv_q   <= '0;
      en_q    <= '0;
      mode_q  <= '1;
      iid_q   <= '0;
      ivec_q  <= '0;
      for (int i = 0; i < NCH; i++) begin
        vec_q[i] <= AW'(VEC_BASE + (32'(i) * VEC_STRIDE));
      end
    end else begin
      state_q <= state_d;
      irq_d_q <= irq;
      pend_q  <= pend_d;
      isv_q   <= isv_d;
      en_q    <= en_d;
      mode_q  <= mode_d;
      iid_q   <= iid_d;
      ivec_q  <= ivec_d;
      for (int i = 0; i < NCH; i++) begin
        vec_q[i] <= vec_d[i];
      end
    end
  end

  assign int_req    = (state_q == S_REQ);
  assign int_vec    = ivec_q;
  assign int_id     = iid_q;
  assign pending    = pend_q;
  assign in_service = isv_q;

endmodule

// File: tb/tb_int_ctrl.sv
// Directed scenarios then random traffic on int_ctrl, compared each cycle against a behavioural model.
module tb_int_ctrl;
  localparam int NCH = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] irq, en_in, mode_in;
  logic       we_en, we_mode, we_vec, int_ack, int_ret;
  logic [1:0] vec_sel;
  logic [9:0] vec_in;
  logic       int_req;
  logic [9:0] int_vec;
  logic [1:0] int_id;
  logic [3:0] pending, in_service;

  // Second instance with a non-power-of-two channel count for out-of-range writes.
  logic [4:0] d2_irq, d2_en_in;
  logic       d2_we_en, d2_we_vec;
  logic [2:0] d2_vec_sel;
  logic [9:0] d2_vec_in;
  logic       d2_int_req;
  logic [9:0] d2_int_vec;
  logic [2:0] d2_int_id;
  logic [4:0] d2_pending, d2_in_service;

  int errors = 0;
  int checks = 0;

  bit [3:0]   m_irqd, m_pend, m_is, m_en, m_mode;
  logic [9:0] m_vec [NCH];
  bit         m_req;
  logic [1:0] m_id;
  logic [9:0] m_ivec;

  always #5 clk = ~clk;

  int_ctrl #(.NCH(4), .AW(10), .VEC_BASE(32'h3C0), .VEC_STRIDE(16)) dut (
    .clk(clk), .reset(reset), .irq(irq),
    .we_en(we_en), .en_in(en_in), .we_mode(we_mode), .mode_in(mode_in),
    .we_vec(we_vec), .vec_sel(vec_sel), .vec_in(vec_in),
    .int_ack(int_ack), .int_ret(int_ret),
    .int_req(int_req), .int_vec(int_vec), .int_id(int_id),
    .pending(pending), .in_service(in_service)
  );

  int_ctrl #(.NCH(5), .AW(10), .VEC_BASE(32'h3C0), .VEC_STRIDE(16)) dut2 (
    .clk(clk), .reset(reset), .irq(d2_irq),
    .we_en(d2_we_en), .en_in(d2_en_in), .we_mode(1'b0), .mode_in(5'b0),
    .we_vec(d2_we_vec), .vec_sel(d2_vec_sel), .vec_in(d2_vec_in),
    .int_ack(1'b0), .int_ret(1'b0),
    .int_req(d2_int_req), .int_vec(d2_int_vec), .int_id(d2_int_id),
    .pending(d2_pending), .in_service(d2_in_service)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_irqd = '0; m_pend = '0; m_is = '0; m_en = '0; m_mode = '1;
    m_req = 1'b0; m_id = '0; m_ivec = '0;
    for (int i = 0; i < NCH; i++) m_vec[i] = 10'(32'h3C0 + i * 16);
  endtask

  // One clock of the controller's rules, using the inputs presented this cycle.
  task automatic model_next();
    int lo_is, win, ret_bit;
    bit ack;
    bit [3:0] nis, np;
    lo_is = NCH;
    for (int i = NCH - 1; i >= 0; i--) if (m_is[i]) lo_is = i;
    win = -1;
    for (int i = NCH - 1; i >= 0; i--) if (m_pend[i] && m_en[i] && i < lo_is) win = i;
    ack = m_req && int_ack;
    nis = m_is;
    ret_bit = -1;
    if (int_ret) for (int i = NCH - 1; i >= 0; i--) if (nis[i]) ret_bit = i;
    if (ret_bit >= 0) nis[ret_bit] = 1'b0;
    if (ack) nis[m_id] = 1'b1;
    for (int i = 0; i < NCH; i++) begin
      if (m_mode[i]) np[i] = (irq[i] && !m_irqd[i]) ? 1'b1 : ((ack && m_id == i) ? 1'b0 : m_pend[i]);
      else           np[i] = irq[i];
    end
    if (!m_req) begin
      if (win >= 0) begin m_req = 1'b1; m_id = 2'(win); m_ivec = m_vec[win]; end
    end else if (int_ack) begin
      m_req = 1'b0;
    end
    if (we_en) m_en = en_in;
    if (we_mode) m_mode = mode_in;
    if (we_vec && vec_sel < NCH) m_vec[vec_sel] = vec_in;
    m_is = nis; m_pend = np; m_irqd = irq;
  endtask

  task automatic check_all();
    check("int_req", int_req, m_req);
    check("int_id", int_id, m_id);
    check("int_vec", int_vec, m_ivec);
    check("pending", pending, m_pend);
    check("in_service", in_service, m_is);
  endtask

  task automatic step();
    model_next();
    @(posedge clk);
    #1;
    check_all();
  endtask

  initial begin
    irq = '0; en_in = '0; mode_in = '0; we_en = 0; we_mode = 0; we_vec = 0;
    vec_sel = '0; vec_in = '0; int_ack = 0; int_ret = 0;
    d2_irq = '0; d2_en_in = '0; d2_we_en = 0; d2_we_vec = 0; d2_vec_sel = '0; d2_vec_in = '0;
    model_reset();
    #3;
    check_all();
    check("rst_vec", int_vec, 10'h000);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;

    // Single edge pulse on channel 2
    we_en = 1; en_in = 4'hF; step(); we_en = 0;
    irq = 4'b0100; step();
    check("pend2_set", pending[2], 1'b1);
    check("no_req_yet", int_req, 1'b0);
    irq = 4'b0000; step();
    check("c26_req", int_req, 1'b1);
    check("c26_vec", int_vec, 10'h3E0);
    check("c26_id", int_id, 2'd2);
    int_ack = 1; step(); int_ack = 0;
    check("c26_isv", in_service, 4'b0100);
    check("c26_pend2_clr", pending[2], 1'b0);
    int_ret = 1; step(); int_ret = 0;

    // Simultaneous 3 and 1, nesting blocks the lower-priority one
    irq = 4'b1010; step(); irq = 4'b0000; step();
    check("c27_id1", int_id, 2'd1);
    int_ack = 1; step(); int_ack = 0;
    step(); step();
    check("c27_blocked", int_req, 1'b0);
    int_ret = 1; step(); int_ret = 0;
    step();
    check("c27_req3", int_req, 1'b1);
    check("c27_id3", int_id, 2'd3);
    check("c27_vec3", int_vec, 10'h3F0);
    int_ack = 1; step(); int_ack = 0;
    int_ret = 1; step(); int_ret = 0;

    // Preemption of channel 2 by channel 0
    irq = 4'b0100; step(); irq = 4'b0000; step();
    int_ack = 1; step(); int_ack = 0;
    irq = 4'b0001; step(); irq = 4'b0000; step();
    check("c28_preempt", int_id, 2'd0);
    int_ack = 1; step(); int_ack = 0;
    check("c28_nested", in_service, 4'b0101);
    int_ret = 1; step();
    check("c28_ret0", in_service, 4'b0100);
    step(); int_ret = 0;
    check("c28_ret2", in_service, 4'b0000);

    // Level mode on channel 1
    we_mode = 1; mode_in = 4'b1101; step(); we_mode = 0;
    irq = 4'b0010; step(); step();
    check("c29_req", int_id, 2'd1);
    int_ack = 1; step(); int_ack = 0;
    check("c29_pend_held", pending[1], 1'b1);
    int_ret = 1; step(); int_ret = 0;
    step();
    check("c29_rereq", int_req, 1'b1);
    int_ack = 1; step(); int_ack = 0;
    irq = 4'b0000; int_ret = 1; step(); int_ret = 0;
    step();
    check("c29_pend_low", pending[1], 1'b0);
    check("c29_no_req", int_req, 1'b0);
    we_mode = 1; mode_in = 4'hF; step(); we_mode = 0;

    // Stable grant while requests change, then reset mid-REQ
    irq = 4'b0100; step(); irq = 4'b0000; step();
    irq = 4'b0001; we_en = 1; en_in = 4'b1011; step();
    irq = 4'b0000; we_en = 0; step();
    check("c30_id_hold", int_id, 2'd2);
    check("c30_vec_hold", int_vec, 10'h3E0);
    int_ack = 1; step(); int_ack = 0;
    step();
    check("c30_req0", int_req, 1'b1);
    reset = 1'b1; #2;
    model_reset();
    check_all();
    check("c30_rst_req", int_req, 1'b0);
    #2 reset = 1'b0;
    we_en = 1; en_in = 4'hF; step(); we_en = 0;
    step();
    check("c30_no_ack_needed", int_req, 1'b0);

    // Vector table write
    we_vec = 1; vec_sel = 2'd1; vec_in = 10'h155; step(); we_vec = 0;
    irq = 4'b0010; step(); irq = 4'b0000; step();
    check("c31_vec", int_vec, 10'h155);
    int_ack = 1; step(); int_ack = 0;
    int_ret = 1; step(); int_ret = 0;

    // Out-of-range write on a 5-channel instance; channel 4 vector wraps to 0
    d2_we_en = 1; d2_en_in = 5'h1F; d2_we_vec = 1; d2_vec_sel = 3'd5; d2_vec_in = 10'h2AA; step();
    d2_vec_sel = 3'd7; d2_we_en = 0; step();
    d2_we_vec = 0; d2_irq = 5'b10000; step(); d2_irq = 5'b0; step();
    check("d2_req", d2_int_req, 1'b1);
    check("d2_id", d2_int_id, 3'd4);
    check("d2_vec_wrap", d2_int_vec, 10'h000);
    check("d2_pend", d2_pending, 5'b10000);
    check("d2_isv", d2_in_service, 5'b00000);

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      irq     = 4'($urandom);
      int_ack = int_req ? ($urandom_range(0, 2) != 0) : 1'($urandom_range(0, 1));
      int_ret = ($urandom_range(0, 4) == 0);
      we_en   = ($urandom_range(0, 15) == 0);
      en_in   = 4'($urandom) | 4'b0001;
      we_mode = ($urandom_range(0, 15) == 0);
      mode_in = 4'($urandom);
      we_vec  = ($urandom_range(0, 15) == 0);
      vec_sel = 2'($urandom);
      vec_in  = 10'($urandom);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
